// File: rtl/io_sched_pkg.sv
// Shared types and widths for the I/O port scheduler.
package io_sched_pkg;

    localparam int unsigned NUM_PORTS = 4;
    localparam int unsigned PORT_W    = 2;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned CNT_W     = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CPU_WR   = 3'd1,
        CPU_RD   = 3'd2,
        POLL_SEL = 3'd3,
        POLL_CAP = 3'd4
    } state_e;

endpackage

// File: rtl/io_poll_timer.sv
// Background poll interval timer: pulses tick once every POLL_DIV enabled cycles.
module io_poll_timer
    import io_sched_pkg::*;
#(
    parameter int unsigned POLL_DIV = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(POLL_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             tick_q;

    // Disabling holds the counter at its reload value so the next period starts clean.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            cnt_q  <= RELOAD;
            tick_q <= 1'b0;
        end else if (cnt_q == '0) begin
            cnt_q  <= RELOAD;
            tick_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_q - 1'b1;
            tick_q <= 1'b0;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/io_port_scheduler.sv
// Arbitrates CPU port accesses against background input polling and
// raises per-port change interrupts from the polled input shadows.
module io_port_scheduler
    import io_sched_pkg::*;
#(
    parameter int unsigned POLL_DIV = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [PORT_W-1:0]    cpu_port,
    input  logic [DATA_W-1:0]    cpu_wdata,
    output logic                 cpu_ack,
    output logic [DATA_W-1:0]    cpu_rdata,
    output logic [PORT_W-1:0]    io_sel_port,
    output logic                 io_we,
    output logic [DATA_W-1:0]    io_wdata,
    input  logic [DATA_W-1:0]    io_rdata,
    input  logic                 poll_en,
    input  logic [NUM_PORTS-1:0] irq_clr,
    output logic [NUM_PORTS-1:0] irq_pending,
    output logic                 irq
);

    state_e                state_q;
    logic                  cpu_ack_q;
    logic [DATA_W-1:0]     cpu_rdata_q;
    logic [PORT_W-1:0]     io_sel_port_q;
    logic                  io_we_q;
    logic [DATA_W-1:0]     io_wdata_q;
    logic [PORT_W-1:0]     poll_ptr_q;
    logic [DATA_W-1:0]     shadow_q [NUM_PORTS];
    logic                  poll_due_q, poll_due_d;
    logic [NUM_PORTS-1:0]  irq_pending_q, irq_pending_d;
    logic                  irq_q;
    logic                  poll_tick;
    logic                  poll_start;
    logic [NUM_PORTS-1:0]  poll_set;

    io_poll_timer #(
        .POLL_DIV (POLL_DIV)
    ) u_poll_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (poll_en),
        .tick   (poll_tick)
    );

    assign poll_start = (state_q == IDLE) && !cpu_req && poll_due_q;

    // A single pending poll is remembered; a fresh expiry on the consume cycle re-arms it.
    always_comb begin
        poll_due_d = poll_en && (poll_tick || (poll_due_q && !poll_start));
    end

    // Change detection; a set in the same cycle as a clear takes precedence.
    always_comb begin
        poll_set = '0;
        if (state_q == POLL_CAP && io_rdata != shadow_q[poll_ptr_q]) begin
            poll_set[poll_ptr_q] = 1'b1;
        end
        irq_pending_d = (irq_pending_q & ~irq_clr) | poll_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            poll_due_q    <= 1'b0;
            irq_pending_q <= '0;
            irq_q         <= 1'b0;
        end else begin
            poll_due_q    <= poll_due_d;
            irq_pending_q <= irq_pending_d;
            irq_q         <= |irq_pending_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cpu_ack_q     <= 1'b0;
            cpu_rdata_q   <= '0;
            io_sel_port_q <= '0;
            io_we_q       <= 1'b0;
            io_wdata_q    <= '0;
            poll_ptr_q    <= '0;
            for (int i = 0; i < int'(NUM_PORTS); i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        io_sel_port_q <= cpu_port;
                        if (cpu_we) begin
                            io_wdata_q <= cpu_wdata;
                            io_we_q    <= 1'b1;
                            cpu_ack_q  <= 1'b1;
                            state_q    <= CPU_WR;
                        end else begin
                            state_q    <= CPU_RD;
                        end
                    end else if (poll_due_q) begin
                        io_sel_port_q <= poll_ptr_q;
                        state_q       <= POLL_SEL;
                    end
                end
                CPU_WR: begin
                    io_we_q   <= 1'b0;
                    cpu_ack_q <= 1'b0;
                    state_q   <= IDLE;
                end
                // First cycle captures the selected input and acks; second cycle retires.
                CPU_RD: begin
                    if (!cpu_ack_q) begin
                        cpu_rdata_q <= io_rdata;
                        cpu_ack_q   <= 1'b1;
                    end else begin
                        cpu_ack_q   <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                POLL_SEL: begin
                    state_q <= POLL_CAP;
                end
                POLL_CAP: begin
                    shadow_q[poll_ptr_q] <= io_rdata;
                    poll_ptr_q           <= poll_ptr_q + PORT_W'(1);
                    state_q              <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cpu_ack     = cpu_ack_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign io_sel_port = io_sel_port_q;
    assign io_we       = io_we_q;
    assign io_wdata    = io_wdata_q;
    assign irq_pending = irq_pending_q;
    assign irq         = irq_q;

endmodule

// File: doc/io_port_scheduler.md
IO_PORT_SCHEDULER -- requirements
Module: io_port_scheduler

Interface
REQ-001 Parameter POLL_DIV, default 8: cycles between background input-port polls; legal range 2..255.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cpu_req  input  1  CPU I/O access request; held high until cpu_ack.
REQ-005 cpu_we  input  1  1 = write to an output port, 0 = read from an input port; valid while cpu_req is high.
REQ-006 cpu_port  input  2  target port 0..3; valid while cpu_req is high.
REQ-007 cpu_wdata  input  8  write data; valid while cpu_req is high.
REQ-008 cpu_ack  output  1  one-cycle completion pulse.
REQ-009 cpu_rdata  output  8  read result; valid in the cpu_ack cycle of a read, held until the next read completes.
REQ-010 io_sel_port  output  2  port select to the I/O module.
REQ-011 io_we  output  1  output-port write strobe to the I/O module.
REQ-012 io_wdata  output  8  write data to the I/O module.
REQ-013 io_rdata  input  8  selected input-port value from the I/O module; reflects io_sel_port one cycle later.
REQ-014 poll_en  input  1  enables background polling.
REQ-015 irq_clr  input  4  write-1-to-clear for the pending bits.
REQ-016 irq_pending  output  4  per-port input-change flags.
REQ-017 irq  output  1  OR of irq_pending.

Function
REQ-018 The FSM SHALL have exactly these states: IDLE, CPU_WR, CPU_RD, POLL_SEL, POLL_CAP.
REQ-019 In IDLE with cpu_req=1 at edge N, the FSM SHALL go to CPU_WR (cpu_we=1) or CPU_RD (cpu_we=0), latching cpu_port and cpu_wdata.
REQ-020 CPU_WR: for exactly the cycle after edge N, drive io_sel_port=port, io_wdata=data, io_we=1 and cpu_ack=1; then return to IDLE.
REQ-021 CPU_RD: io_sel_port=port from cycle N+1; at edge N+2, capture io_rdata into cpu_rdata; cpu_ack=1 in cycle N+2; return to IDLE.
REQ-022 io_we SHALL be 1 only in CPU_WR; it is never asserted by polling.
REQ-023 Poll timer: an 8-bit down-counter runs while poll_en=1, reloads POLL_DIV-1 on reaching 0, and sets poll_due on that cycle; poll_en=0 SHALL reload the counter and clear poll_due.
REQ-024 Sequencing SHALL be as follows: in IDLE, cpu_req has priority over poll_due; with cpu_req=0 and poll_due=1, go to POLL_SEL and clear poll_due.
REQ-025 POLL_SEL SHALL drive io_sel_port=poll_ptr for 1 cycle, then go to POLL_CAP.
REQ-026 POLL_CAP SHALL sample io_rdata, compare it with shadow[poll_ptr], and on any difference set irq_pending[poll_ptr].
REQ-027 POLL_CAP SHALL then update shadow[poll_ptr], advance poll_ptr modulo 4 (3 wraps to 0), and return to IDLE.
REQ-028 A cpu_req arriving during a poll SHALL wait until IDLE; latency from poll start is at most 2 extra cycles.
REQ-029 A poll_due that occurs while busy SHALL remain pending; only one poll_due SHALL be stored, and extra expiries are dropped.
REQ-030 cpu_req still high in the IDLE cycle after cpu_ack SHALL be treated as a new request.
REQ-031 irq_clr SHALL clear pending bits at the edge; if a set and a clear of the same bit coincide, the set SHALL win.
REQ-032 In IDLE, io_sel_port SHALL hold its last value and io_wdata SHALL hold its last value.

Reset
REQ-033 On reset, state=IDLE, cpu_ack=0, cpu_rdata=0, io_sel_port=0, io_we=0, io_wdata=0.
REQ-034 On reset, irq_pending=0, irq=0, poll_ptr=0, all shadows=0, poll_due=0, and the counter reloads POLL_DIV-1.
REQ-035 Reset SHALL abort any in-flight access without an ack; the cycle after reset is IDLE.

Structure
REQ-036 A shared package io_sched_pkg SHALL hold the state enumeration, NUM_PORTS=4, PORT_W=2 and DATA_W=8.
REQ-037 The poll counter SHALL be the sub-module io_poll_timer (ports clk, reset, enable, tick); the FSM and shadows SHALL be in the top module.

Verification
REQ-038 Write: cpu_req=1, we=1, port=2, wdata=0xA5 at edge N -> io_we=1, io_sel_port=2, io_wdata=0xA5, cpu_ack=1 in cycle N+1 only.
REQ-039 Read: port=1, io_rdata returns 0x3C -> cpu_ack and cpu_rdata=0x3C in cycle N+2; io_we stays 0.
REQ-040 Poll: POLL_DIV=4, poll_en=1, port 3 input changes 0x00->0x81 -> within 4 poll rounds irq_pending=4'b1000 and irq=1.
REQ-041 Poll: irq_clr=4'b1000 with no new change -> pending clears and stays 0 on re-poll.
REQ-042 Collision: cpu_req and poll_due coincide -> CPU is served first; poll follows; poll_ptr advances 0->1; a later poll of port 3 wraps poll_ptr to 0.
REQ-043 Reset mid-read in CPU_RD -> no cpu_ack, all outputs zero the next cycle.
REQ-044 Set/clear race: a change on port 0 detected in the same cycle as irq_clr[0]=1 -> irq_pending[0]=1.
